// File: rtl/seq_det_pkg.sv
// Shared constants and the KMP-style transition function for the parametrised sequence detector.
package seq_det_pkg;

    localparam int MAX_PAT_W = 16;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } ovl_mode_e;

    function automatic int st_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Longest j <= min(k+1, pat_w) where the last j bits of (prefix_k, din) equal the first j pattern bits.
    // Pattern bit i (i = 0 is received first) lives at pat[pat_w-1-i].
    function automatic logic [4:0] match_len(
        input logic [MAX_PAT_W-1:0] pat,
        input int                   pat_w,
        input int                   k,
        input logic                 din,
        input logic                 ovl
    );
        int         klen;
        int         lim;
        int         idx;
        logic       ok;
        logic       found;
        logic       sb;
        logic [4:0] res;

        klen  = (k >= pat_w && ovl_mode_e'(ovl) == MODE_NONOVL) ? 0 : k;
        lim   = (klen + 1 < pat_w) ? klen + 1 : pat_w;
        res   = '0;
        found = 1'b0;
        for (int j = MAX_PAT_W; j >= 1; j--) begin
            if (!found && j <= lim) begin
                ok = 1'b1;
                for (int t = 0; t < MAX_PAT_W; t++) begin
                    if (t < j) begin
                        idx = klen + 1 - j + t;
                        sb  = (idx == klen) ? din : pat[4'(pat_w - 1 - idx)];
                        if (sb != pat[4'(pat_w - 1 - t)]) ok = 1'b0;
                    end
                end
                if (ok) begin
                    res   = 5'(j);
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-state function of the sequence detector (thin wrapper around match_len).
module seq_det_next
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 3
) (
    input  logic [MAX_PAT_W-1:0]    i_pat,
    input  logic [st_w(PAT_W)-1:0]  i_k,
    input  logic                    i_din,
    input  logic                    i_ovl,
    output logic [st_w(PAT_W)-1:0]  o_next
);

    localparam int ST_W = st_w(PAT_W);

    assign o_next = ST_W'(match_len(i_pat, PAT_W, int'(i_k), i_din, i_ovl));

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector with run-time pattern load and overlap select.
// Optional saturating match counter is enabled by defining SEQ_DET_CNT_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    din,
    input  logic                    overlap,
    input  logic                    pat_load,
    input  logic [PAT_W-1:0]        pat_in,
    output logic                    detect,
    output logic [st_w(PAT_W)-1:0]  state
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0]        match_cnt
`endif
);

    localparam int ST_W = st_w(PAT_W);

    logic [PAT_W-1:0]     r_pat;
    logic [ST_W-1:0]      r_state;
    logic [ST_W-1:0]      w_next;
    logic [MAX_PAT_W-1:0] w_pat_ext;

    assign w_pat_ext = MAX_PAT_W'(r_pat);

    seq_det_next #(
        .PAT_W (PAT_W)
    ) u_next (
        .i_pat  (w_pat_ext),
        .i_k    (r_state),
        .i_din  (din),
        .i_ovl  (overlap),
        .o_next (w_next)
    );

    // A pattern load restarts matching and drops whatever bit arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat   <= PATTERN;
            r_state <= '0;
        end else if (pat_load) begin
            r_pat   <= pat_in;
            r_state <= '0;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    assign state  = r_state;
    assign detect = (r_state == ST_W'(PAT_W));

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!pat_load && en && w_next == ST_W'(PAT_W) && r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_cnt = r_cnt;
`endif

endmodule
